// File: rtl/paddle_ctrl_pkg.sv
// Shared Pong definitions: screen geometry, direction and paddle FSM encodings.
package paddle_ctrl_pkg;

   localparam int unsigned Y_MAX    = 480;
   localparam int unsigned PADDLE_H = 64;
   localparam int unsigned PADDLE_W = 8;
   localparam int unsigned Y_W      = 10;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DOWN = 2'd2
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } paddle_state_e;

   // Both buttons (or neither) resolve to no motion.
   function automatic dir_e decode_dir(input logic up, input logic down);
      if (up && !down) begin
         return DIR_UP;
      end else if (down && !up) begin
         return DIR_DOWN;
      end
      return DIR_NONE;
   endfunction

endpackage

// File: rtl/paddle_ctrl_step_clamp.sv
// Combinational one-step move of a Y coordinate, clamped to [0, limit_i].
module step_clamp
   import paddle_ctrl_pkg::*;
(
   input  logic [Y_W-1:0] y_i,
   input  dir_e           dir_i,
   input  logic [Y_W-1:0] step_i,
   input  logic [Y_W-1:0] limit_i,
   output logic [Y_W-1:0] y_o
);

   logic [Y_W:0] y_w;
   logic [Y_W:0] step_w;
   logic [Y_W:0] lim_w;
   logic [Y_W:0] sum_w;

   // Widen by one bit so neither the add nor the subtract can wrap.
   always_comb begin
      y_w    = (Y_W+1)'(y_i);
      step_w = (Y_W+1)'(step_i);
      lim_w  = (Y_W+1)'(limit_i);
      sum_w  = y_w + step_w;
      y_o    = y_i;
      case (dir_i)
         DIR_UP:   y_o = (y_w < step_w) ? '0 : Y_W'(y_w - step_w);
         DIR_DOWN: y_o = (sum_w > lim_w) ? limit_i : Y_W'(sum_w);
         default:  y_o = y_i;
      endcase
   end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: immediate step on press, auto-repeat after a hold delay.
module paddle_ctrl
   import paddle_ctrl_pkg::*;
#(
   parameter int unsigned Y_INIT        = 208,
   parameter int unsigned STEP          = 8,
   parameter int unsigned HOLD_DELAY    = 15000000,
   parameter int unsigned REPEAT_PERIOD = 1000000
) (
   input  logic           CLOCK_50,
   input  logic           reset_n,
   input  logic           en,
   input  logic           btn_up,
   input  logic           btn_down,
   output logic [Y_W-1:0] paddle_y,
   output logic           moved,
   output logic           at_top,
   output logic           at_bottom
);

   localparam int unsigned CNT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_DELAY - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [Y_W-1:0]   Y_LIMIT     = Y_W'(Y_MAX - PADDLE_H);
   localparam logic [Y_W-1:0]   Y_RESET     = Y_W'(Y_INIT);
   localparam logic [Y_W-1:0]   STEP_V      = Y_W'(STEP);

   paddle_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   dir_e             dir_q, dir_d;
   logic [Y_W-1:0]   y_q, y_d;
   logic             moved_q, moved_d;
   logic             at_top_q, at_bottom_q;
   dir_e             dir_c;
   logic             step_en_c;
   logic [CNT_W-1:0] last_c;
   logic [Y_W-1:0]   y_step_c;

   assign dir_c = decode_dir(btn_up, btn_down);

   step_clamp u_step_clamp (
      .y_i     (y_q),
      .dir_i   (dir_c),
      .step_i  (STEP_V),
      .limit_i (Y_LIMIT),
      .y_o     (y_step_c)
   );

   // FSM next state, counter and step decision.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      step_en_c = 1'b0;
      last_c    = (state_q == ST_HOLD) ? HOLD_LAST : REPEAT_LAST;
      if (!en) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (dir_c != DIR_NONE) begin
                  step_en_c = 1'b1;
                  cnt_d     = '0;
                  state_d   = ST_HOLD;
               end
            end
            ST_HOLD, ST_REPEAT: begin
               if (dir_c == DIR_NONE) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (dir_c != dir_q) begin
                  step_en_c = 1'b1;
                  cnt_d     = '0;
                  state_d   = ST_HOLD;
               end else if (cnt_q == last_c) begin
                  step_en_c = 1'b1;
                  cnt_d     = '0;
                  state_d   = ST_REPEAT;
               end else begin
                  cnt_d = CNT_W'(cnt_q + 1'b1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      dir_d   = en ? dir_c : DIR_NONE;
      y_d     = step_en_c ? y_step_c : y_q;
      moved_d = (y_d != y_q);
   end

   // State, counter, position and status registers.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         dir_q       <= DIR_NONE;
         y_q         <= Y_RESET;
         moved_q     <= 1'b0;
         at_top_q    <= (Y_RESET == '0);
         at_bottom_q <= (Y_RESET == Y_LIMIT);
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dir_q       <= dir_d;
         y_q         <= y_d;
         moved_q     <= moved_d;
         at_top_q    <= (y_d == '0);
         at_bottom_q <= (y_d == Y_LIMIT);
      end
   end

   assign paddle_y  = y_q;
   assign moved     = moved_q;
   assign at_top    = at_top_q;
   assign at_bottom = at_bottom_q;

endmodule
